// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: op codes, response bytes and FSM states for the UART RAM command controller
package uart_cmd_pkg;
    localparam logic [3:0] OP_PING   = 4'h0;
    localparam logic [3:0] OP_WRITE  = 4'h1;
    localparam logic [3:0] OP_READ   = 4'h2;
    localparam logic [3:0] OP_STATUS = 4'h3;
    localparam logic [3:0] OP_LED    = 4'hF;
    localparam logic [7:0] ACK       = 8'h06;
    localparam logic [7:0] NAK       = 8'h15;
    localparam logic [7:0] PING_RESP = 8'hA5;
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_WR_DATA, S_RD_ADDR, S_RD_LATCH, S_RD_SEND, S_RESP, S_TX_WAIT
    } state_t;
endpackage

// File: rtl/uart_cmd_timer.sv
// uart_cmd_timer: loadable down-counter that stops at zero
module uart_cmd_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] count;
    // reload on request, otherwise count down until exhausted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (load) count <= value;
        else if (count != '0) count <= count - 1'b1;
    end
    assign zero = (count == '0);
endmodule

// File: rtl/uart_ram_cmd_ctrl.sv
// uart_ram_cmd_ctrl: byte-command interpreter giving UART access to a bank of byte RAMs
module uart_ram_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 10,
    parameter int LED_CYC     = 50000000,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_start,
    input  logic                tx_busy,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [7:0]          ram_wdata,
    output logic [NUM_CH-1:0]   ram_we,
    input  logic [NUM_CH*8-1:0] ram_rdata,
    output logic                led,
    output logic                busy
);
    localparam logic [NUM_CH-1:0] WE_ONE = NUM_CH'(1);
    state_t            state;
    logic [3:0]        op, ch;
    logic [1:0]        hdr_idx;
    logic [23:0]       hdr;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   len, cnt;
    logic [7:0]        resp, rd_byte;
    logic              rd_mode, tmo_zero, led_zero;
    logic [31:0]       hdr_full;
    logic [ADDR_W:0]   hdr_len;
    logic              ch_bad, rx_take, led_load;
    // header assembly, channel range check and timer load strobes
    always_comb begin
        hdr_full = {hdr, rx_data};
        hdr_len  = (hdr_full[ADDR_W-1:0] == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, hdr_full[ADDR_W-1:0]};
        ch_bad   = {1'b0, ch} >= 5'(NUM_CH);
        rx_take  = rx_ready && (state == S_IDLE || state == S_HDR || state == S_WR_DATA);
        led_load = rx_ready && state == S_IDLE && rx_data[7:4] == OP_LED;
        rd_byte  = ram_rdata[8*int'(ch) +: 8];
    end
    uart_cmd_timer #(.W(32)) u_tmo (
        .clk(clk), .rst(rst), .load(rx_take), .value(32'(TIMEOUT_CYC)), .zero(tmo_zero)
    );
    uart_cmd_timer #(.W(32)) u_led (
        .clk(clk), .rst(rst), .load(led_load), .value(32'(LED_CYC)), .zero(led_zero)
    );
    assign led  = !led_zero;
    assign busy = (state != S_IDLE);
    // command FSM with registered TX and RAM outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE; op <= '0; ch <= '0; hdr_idx <= '0; hdr <= '0;
            addr <= '0; len <= '0; cnt <= '0; resp <= '0; rd_mode <= 1'b0;
            tx_data <= '0; tx_start <= 1'b0; ram_addr <= '0; ram_wdata <= '0; ram_we <= '0;
        end else begin
            tx_start <= 1'b0;
            ram_we   <= '0;
            case (state)
                S_IDLE: if (rx_ready) begin
                    op      <= rx_data[7:4];
                    ch      <= rx_data[3:0];
                    hdr_idx <= '0;
                    rd_mode <= 1'b0;
                    state   <= (rx_data[7:4] == OP_WRITE || rx_data[7:4] == OP_READ) ? S_HDR : S_RESP;
                    resp    <= rx_data[7:4] == OP_PING   ? PING_RESP :
                               rx_data[7:4] == OP_STATUS ? {4'(NUM_CH), 4'(ADDR_W)} :
                               rx_data[7:4] == OP_LED    ? ACK : NAK;
                end
                S_HDR: if (rx_ready) begin
                    hdr     <= hdr_full[23:0];
                    hdr_idx <= hdr_idx + 1'b1;
                    if (hdr_idx == 2'd3) begin
                        addr    <= hdr_full[16 +: ADDR_W];
                        len     <= hdr_len;
                        cnt     <= '0;
                        resp    <= NAK;
                        rd_mode <= !ch_bad && op == OP_READ;
                        state   <= ch_bad ? S_RESP : (op == OP_WRITE ? S_WR_DATA : S_RD_ADDR);
                    end
                end else if (tmo_zero) begin
                    resp  <= NAK;
                    state <= S_RESP;
                end
                S_WR_DATA: if (rx_ready) begin
                    ram_addr  <= addr;
                    ram_wdata <= rx_data;
                    ram_we    <= WE_ONE << ch;
                    addr      <= addr + 1'b1;
                    cnt       <= cnt + 1'b1;
                    if (cnt + 1'b1 == len) begin
                        resp  <= ACK;
                        state <= S_RESP;
                    end
                end else if (tmo_zero) begin
                    resp  <= NAK;
                    state <= S_RESP;
                end
                S_RD_ADDR: begin
                    ram_addr <= addr;
                    state    <= S_RD_LATCH;
                end
                S_RD_LATCH: state <= S_RD_SEND;
                S_RD_SEND: if (!tx_busy) begin
                    tx_data  <= rd_byte;
                    tx_start <= 1'b1;
                    addr     <= addr + 1'b1;
                    cnt      <= cnt + 1'b1;
                    state    <= S_TX_WAIT;
                end
                S_RESP: if (!tx_busy) begin
                    tx_data  <= resp;
                    tx_start <= 1'b1;
                    state    <= S_TX_WAIT;
                end
                S_TX_WAIT: state <= (rd_mode && cnt != len) ? S_RD_ADDR : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_ram_cmd_ctrl.sv
// tb_uart_ram_cmd_ctrl: directed scenario bench with RAM and transmitter models
module tb_uart_ram_cmd_ctrl;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 10;
    localparam int LED_CYC = 200;
    localparam int TMO = 300;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic rx_ready = 1'b0;
    logic [7:0] tx_data;
    logic tx_start;
    logic tx_busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [NUM_CH-1:0] ram_we;
    logic [NUM_CH*8-1:0] ram_rdata;
    logic led, busy;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int busy_len = 0;
    int busy_cnt = 0;
    int viol = 0;
    int we_cnt = 0;
    int we_bad = 0;
    int last_rx = 0;
    logic [7:0] tx_log[$];
    int tx_cyc[$];
    logic [7:0] mem[NUM_CH][1 << ADDR_W];

    uart_ram_cmd_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LED_CYC(LED_CYC), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready), .tx_data(tx_data),
        .tx_start(tx_start), .tx_busy(tx_busy), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_rdata(ram_rdata), .led(led), .busy(busy)
    );

    always #5 clk = ~clk;
    assign tx_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (ram_we[c]) mem[c][ram_addr] <= ram_wdata;
            ram_rdata[8*c +: 8] <= mem[c][ram_addr];
        end
        if (ram_we != '0) begin
            we_cnt <= we_cnt + 1;
            if (!$onehot(ram_we)) we_bad <= we_bad + 1;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_start) begin
            if (tx_busy) viol <= viol + 1;
            tx_log.push_back(tx_data);
            tx_cyc.push_back(cyc);
            busy_cnt <= busy_len;
        end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    function automatic logic [7:0] tx_at(input int i);
        return (tx_log.size() > i) ? tx_log[i] : 8'hxx;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_ready = 1'b1;
        last_rx = cyc;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (tx_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (tx_log.size() < n) begin
            miscompares++;
            $display("FAIL tx_wait got %0d bytes exp %0d", tx_log.size(), n);
        end
    endtask

    task automatic test_reset;
        #1;
        vectors += 7;
        if (tx_start !== 1'b0) begin miscompares++; $display("FAIL rst_tx_start got %b exp 0", tx_start); end
        if (ram_we !== '0) begin miscompares++; $display("FAIL rst_ram_we got %b exp 0", ram_we); end
        if (led !== 1'b0) begin miscompares++; $display("FAIL rst_led got %b exp 0", led); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", busy); end
        if (tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_tx_data got %h exp 00", tx_data); end
        if (ram_addr !== '0) begin miscompares++; $display("FAIL rst_ram_addr got %h exp 0", ram_addr); end
        if (ram_wdata !== 8'h00) begin miscompares++; $display("FAIL rst_ram_wdata got %h exp 00", ram_wdata); end
    endtask

    task automatic test_simple(input logic [7:0] cmd, input logic [7:0] exp, input string name);
        int base = tx_log.size();
        send_byte(cmd);
        wait_tx(base + 1, 50);
        repeat (20) @(negedge clk);
        vectors += 3;
        if (tx_at(base) !== exp) begin miscompares++; $display("FAIL %s_byte got %h exp %h", name, tx_at(base), exp); end
        if (tx_log.size() !== base + 1) begin miscompares++; $display("FAIL %s_count got %0d exp %0d", name, tx_log.size() - base, 1); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy got %b exp 0", name, busy); end
    endtask

    task automatic test_write_wrap;
        int base = tx_log.size();
        int we0 = we_cnt;
        logic [7:0] d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [ADDR_W-1:0] a[4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        send_byte(8'h12); send_byte(8'h03); send_byte(8'hFE); send_byte(8'h00); send_byte(8'h04);
        for (int i = 0; i < 4; i++) send_byte(d[i]);
        wait_tx(base + 1, 50);
        repeat (5) @(negedge clk);
        vectors += 3;
        if (tx_at(base) !== 8'h06) begin miscompares++; $display("FAIL wr_ack got %h exp 06", tx_at(base)); end
        if (we_cnt - we0 !== 4) begin miscompares++; $display("FAIL wr_we_count got %0d exp 4", we_cnt - we0); end
        if (we_bad !== 0) begin miscompares++; $display("FAIL wr_we_onehot got %0d exp 0", we_bad); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (mem[2][a[i]] !== d[i]) begin miscompares++; $display("FAIL wr_mem%0d got %h exp %h", i, mem[2][a[i]], d[i]); end
        end
    endtask

    task automatic test_read_busy;
        int base = tx_log.size();
        logic [7:0] d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        busy_len = 100;
        send_byte(8'h22); send_byte(8'h03); send_byte(8'hFE); send_byte(8'h00); send_byte(8'h04);
        wait_tx(base + 4, 1500);
        repeat (300) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (tx_at(base + i) !== d[i]) begin miscompares++; $display("FAIL rd_byte%0d got %h exp %h", i, tx_at(base + i), d[i]); end
        end
        vectors += 3;
        if (tx_log.size() - base !== 4) begin miscompares++; $display("FAIL rd_count got %0d exp 4", tx_log.size() - base); end
        if (viol !== 0) begin miscompares++; $display("FAIL rd_start_while_busy got %0d exp 0", viol); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_busy got %b exp 0", busy); end
        busy_len = 0;
    endtask

    task automatic test_bad_ch;
        int base = tx_log.size();
        int we0 = we_cnt;
        send_byte(8'h17); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        wait_tx(base + 1, 50);
        repeat (5) @(negedge clk);
        vectors += 2;
        if (tx_at(base) !== 8'h15) begin miscompares++; $display("FAIL badch_nak got %h exp 15", tx_at(base)); end
        if (we_cnt !== we0) begin miscompares++; $display("FAIL badch_we got %0d exp 0", we_cnt - we0); end
    endtask

    task automatic test_timeout;
        int base = tx_log.size();
        int dt;
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hAA); send_byte(8'hBB);
        wait_tx(base + 1, TMO + 100);
        repeat (3) @(negedge clk);
        dt = (tx_cyc.size() > base) ? tx_cyc[base] - last_rx : -1;
        vectors += 5;
        if (tx_at(base) !== 8'h15) begin miscompares++; $display("FAIL tmo_nak got %h exp 15", tx_at(base)); end
        if (dt < TMO || dt > TMO + 8) begin miscompares++; $display("FAIL tmo_delay got %0d exp %0d..%0d", dt, TMO, TMO + 8); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL tmo_busy got %b exp 0", busy); end
        if (mem[0][0] !== 8'hAA) begin miscompares++; $display("FAIL tmo_mem0 got %h exp aa", mem[0][0]); end
        if (mem[0][1] !== 8'hBB) begin miscompares++; $display("FAIL tmo_mem1 got %h exp bb", mem[0][1]); end
    endtask

    task automatic test_led;
        int base = tx_log.size();
        send_byte(8'hF0);
        wait_tx(base + 1, 50);
        vectors += 4;
        if (tx_at(base) !== 8'h06) begin miscompares++; $display("FAIL led_ack got %h exp 06", tx_at(base)); end
        if (led !== 1'b1) begin miscompares++; $display("FAIL led_on got %b exp 1", led); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL led_busy got %b exp 0", busy); end
        repeat (LED_CYC + 20) @(negedge clk);
        if (led !== 1'b0) begin miscompares++; $display("FAIL led_off got %b exp 0", led); end
    endtask

    task automatic test_reset_mid;
        send_byte(8'hF0);
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h08);
        send_byte(8'h01); send_byte(8'h02);
        vectors += 2;
        if (led !== 1'b1) begin miscompares++; $display("FAIL mid_led_pre got %b exp 1", led); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_pre got %b exp 1", busy); end
        @(negedge clk);
        #2 rst = 1'b1;
        test_reset;
        @(negedge clk);
        rst = 1'b0;
        vectors += 2;
        if (mem[0][16] !== 8'h01) begin miscompares++; $display("FAIL mid_mem0 got %h exp 01", mem[0][16]); end
        if (mem[0][17] !== 8'h02) begin miscompares++; $display("FAIL mid_mem1 got %h exp 02", mem[0][17]); end
        test_simple(8'h00, 8'hA5, "post_rst_ping");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_simple(8'h00, 8'hA5, "ping");
        test_simple(8'h30, 8'h4A, "status");
        test_simple(8'h50, 8'h15, "invalid");
        test_write_wrap;
        test_read_busy;
        test_bad_ch;
        test_timeout;
        test_led;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
